// File: rtl/zsx_mem_responder.sv
// zsx_mem_responder: memory-side responder for the ZSX CPU bus.
// 4K x 8 RAM with asynchronous CPU read, a 16-byte I/O window at IO_BASE,
// and a byte-stream program loader that holds the CPU in reset while it fills RAM.
// Optional feature macro: MEM_WRITE_PROTECT_EN (drops CPU writes below PROT_LIMIT
// and flags them on wp_violation).
module zsx_mem_responder #(
    parameter int unsigned       ADDR_W     = 12,
    parameter int unsigned       DATA_W     = 8,
    parameter logic [ADDR_W-1:0] IO_BASE    = 12'hFF0,
    parameter logic [ADDR_W-1:0] PROT_LIMIT = 12'h100
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              write_read,
    input  logic [ADDR_W-1:0] M_address,
    input  logic [DATA_W-1:0] M_data_out,
    output logic [DATA_W-1:0] M_data_in,
    output logic              cpu_reset_n,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] io_out,
    output logic              io_out_strobe,
    output logic [ADDR_W:0]   load_count,
    output logic              wp_violation
);

`ifdef MEM_WRITE_PROTECT_EN
    localparam bit WP_EN = 1'b1;
`else
    localparam bit WP_EN = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] IO_IN_ADDR = IO_BASE + 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     load_count_q, load_count_d;
    logic                cpu_reset_n_q, cpu_reset_n_d;
    logic [DATA_W-1:0]   io_out_q, io_out_d;
    logic                io_out_strobe_q, io_out_strobe_d;
    logic                wp_violation_q, wp_violation_d;
    logic [DATA_W-1:0]   sync1_q, sync1_d;
    logic [DATA_W-1:0]   sync2_q, sync2_d;

    logic [DATA_W-1:0]   mem [2**ADDR_W];

    logic                ld_accept;
    logic                cpu_wr;
    logic                in_io;
    logic                wp_hit;
    logic                cpu_ram_wr;
    logic                io_out_wr;
    logic                ram_we;
    logic [ADDR_W-1:0]   ram_waddr;
    logic [DATA_W-1:0]   ram_wdata;

    // Loader FSM: next state, load pointer and byte count
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        load_count_d = load_count_q;
        ld_accept    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d      = ST_LOAD;
                    ptr_d        = '0;
                    load_count_d = '0;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    ld_accept    = 1'b1;
                    ptr_d        = ptr_q + 1'b1;
                    load_count_d = load_count_q + 1'b1;
                    // Last address filled ends the load even without ld_last.
                    if (ld_last || (ptr_q == '1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (ld_start) begin
                    state_d      = ST_LOAD;
                    ptr_d        = '0;
                    load_count_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CPU bus decode, I/O register, protect flag, CPU reset and synchronizer next values
    always_comb begin
        cpu_wr     = (state_q == ST_RUN) && write_read;
        in_io      = (M_address >= IO_BASE);
        wp_hit     = WP_EN && !in_io && (M_address < PROT_LIMIT);
        cpu_ram_wr = cpu_wr && !in_io && !wp_hit;
        io_out_wr  = cpu_wr && (M_address == IO_BASE);

        io_out_d        = io_out_q;
        io_out_strobe_d = io_out_wr;
        if (io_out_wr) begin
            io_out_d = M_data_out;
        end

        wp_violation_d = wp_violation_q;
        if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) begin
            wp_violation_d = 1'b0;
        end else if (cpu_wr && wp_hit) begin
            wp_violation_d = 1'b1;
        end

        // High only while RUN is both current and next: rises one cycle after
        // entering RUN, falls on the same edge that leaves it.
        cpu_reset_n_d = (state_q == ST_RUN) && (state_d == ST_RUN);

        sync1_d = io_in;
        sync2_d = sync1_q;
    end

    // RAM write port arbitration (loader and CPU are never active together)
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = '0;
        ram_wdata = '0;
        if (ld_accept) begin
            ram_we    = 1'b1;
            ram_waddr = ptr_q;
            ram_wdata = ld_data;
        end else if (cpu_ram_wr) begin
            ram_we    = 1'b1;
            ram_waddr = M_address;
            ram_wdata = M_data_out;
        end
    end

    // Control and output registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            ptr_q           <= '0;
            load_count_q    <= '0;
            cpu_reset_n_q   <= 1'b0;
            io_out_q        <= '0;
            io_out_strobe_q <= 1'b0;
            wp_violation_q  <= 1'b0;
            sync1_q         <= '0;
            sync2_q         <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            load_count_q    <= load_count_d;
            cpu_reset_n_q   <= cpu_reset_n_d;
            io_out_q        <= io_out_d;
            io_out_strobe_q <= io_out_strobe_d;
            wp_violation_q  <= wp_violation_d;
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
        end
    end

    // RAM array write; contents survive reset
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    // Combinational CPU read mux: RAM below IO_BASE, I/O registers inside the window
    always_comb begin
        M_data_in = '0;
        if (!in_io) begin
            M_data_in = mem[M_address];
        end else if (M_address == IO_BASE) begin
            M_data_in = io_out_q;
        end else if (M_address == IO_IN_ADDR) begin
            M_data_in = sync2_q;
        end
    end

    assign cpu_reset_n   = cpu_reset_n_q;
    assign ld_ready      = (state_q == ST_LOAD);
    assign io_out        = io_out_q;
    assign io_out_strobe = io_out_strobe_q;
    assign load_count    = load_count_q;
    assign wp_violation  = wp_violation_q;

endmodule

// File: tb/tb_zsx_mem_responder.sv
// Directed bench for zsx_mem_responder: scoreboard queue of expected values,
// each observation compared with an immediate assertion.
module tb_zsx_mem_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        write_read = 1'b0;
    logic [11:0] M_address = '0;
    logic [7:0]  M_data_out = '0;
    logic [7:0]  M_data_in;
    logic        cpu_reset_n;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic [7:0]  io_in = '0;
    logic [7:0]  io_out;
    logic        io_out_strobe;
    logic [12:0] load_count;
    logic        wp_violation;

    int errors = 0;
    int checks = 0;
    logic [12:0] exp_q[$];

    zsx_mem_responder dut (
        .clock(clock), .reset(reset), .write_read(write_read),
        .M_address(M_address), .M_data_out(M_data_out), .M_data_in(M_data_in),
        .cpu_reset_n(cpu_reset_n), .ld_start(ld_start), .ld_valid(ld_valid),
        .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .io_in(io_in), .io_out(io_out), .io_out_strobe(io_out_strobe),
        .load_count(load_count), .wp_violation(wp_violation)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] pat(input int unsigned i);
        return 8'((i * 7 + 3) & 255);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [12:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [12:0] obs);
        logic [12:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                errors++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
            end
        end
    endtask

    initial begin
        // Reset state
        #2;
        push(0); check("rst_cpu_reset_n", cpu_reset_n);
        push(0); check("rst_ld_ready", ld_ready);
        push(0); check("rst_io_out", io_out);
        push(0); check("rst_strobe", io_out_strobe);
        push(0); check("rst_load_count", load_count);
        push(0); check("rst_wp", wp_violation);
        tick();
        reset = 1'b0;
        tick();

        // Short load of three bytes ending with ld_last
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        push(1); check("load_ready", ld_ready);
        push(0); check("load_count_start", load_count);
        ld_valid = 1'b1; ld_data = 8'h10; tick();
        ld_data = 8'h1D; tick();
        ld_data = 8'hF0; ld_last = 1'b1; tick();
        ld_valid = 1'b0; ld_last = 1'b0;
        push(3); check("load_count_3", load_count);
        push(0); check("load_ready_after", ld_ready);
        push(0); check("cpu_rst_n_entry_cycle", cpu_reset_n);
        tick();
        push(1); check("cpu_rst_n_run", cpu_reset_n);
        M_address = 12'h000; #1; push(8'h10); check("ram0", M_data_in);
        M_address = 12'h001; #1; push(8'h1D); check("ram1", M_data_in);
        M_address = 12'h002; #1; push(8'hF0); check("ram2", M_data_in);

        // CPU write then same-cycle readback
        M_address = 12'h123; M_data_out = 8'h5A; write_read = 1'b1;
        tick();
        write_read = 1'b0;
        push(8'h5A); check("cpu_wr_rd_123", M_data_in);

        // I/O output register and strobe
        M_address = 12'hFF0; M_data_out = 8'hA5; write_read = 1'b1;
        tick();
        write_read = 1'b0;
        push(8'hA5); check("io_out", io_out);
        push(1); check("strobe_hi", io_out_strobe);
        push(8'hA5); check("io_readback", M_data_in);
        tick();
        push(0); check("strobe_lo", io_out_strobe);

        // Write to an unused I/O address is ignored
        M_address = 12'hFF5; M_data_out = 8'h33; write_read = 1'b1;
        tick();
        write_read = 1'b0;
        push(8'hA5); check("io_ignored_out", io_out);
        push(0); check("io_ignored_strobe", io_out_strobe);

        // Input synchronizer latency
        io_in = 8'h3C; M_address = 12'hFF1; #1;
        push(8'h00); check("io_in_0cyc", M_data_in);
        tick();
        push(8'h00); check("io_in_1cyc", M_data_in);
        tick();
        push(8'h3C); check("io_in_2cyc", M_data_in);
        M_address = 12'hFF7; #1;
        push(8'h00); check("io_unused_rd", M_data_in);

        // Restart from RUN
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        push(0); check("restart_cpu_rst_n", cpu_reset_n);
        push(1); check("restart_ld_ready", ld_ready);
        push(0); check("restart_count", load_count);
        ld_valid = 1'b1; ld_data = 8'h66; tick();
        ld_data = 8'h77; tick();
        ld_valid = 1'b0;
        // ld_start and CPU writes are ignored during LOAD
        ld_start = 1'b1; M_address = 12'hFF0; M_data_out = 8'h11; write_read = 1'b1;
        tick();
        ld_start = 1'b0; write_read = 1'b0;
        push(2); check("load_ld_start_ignored", load_count);
        push(1); check("load_still_ready", ld_ready);
        push(8'hA5); check("load_cpu_wr_ignored", io_out);
        push(0); check("load_cpu_wr_no_strobe", io_out_strobe);

        // Asynchronous reset mid-load
        #2; reset = 1'b1; #1;
        push(0); check("midload_rst_ready", ld_ready);
        push(0); check("midload_rst_count", load_count);
        push(0); check("midload_rst_cpu", cpu_reset_n);
        M_address = 12'h000; #1;
        push(8'h66); check("ram_kept0", M_data_in);
        M_address = 12'h001; #1;
        push(8'h77); check("ram_kept1", M_data_in);
        tick();
        reset = 1'b0;
        tick();

        // Full 4096-byte load without ld_last
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        for (int unsigned i = 0; i < 4096; i++) begin
            ld_valid = 1'b1;
            ld_data  = pat(i);
            if (i == 4095) begin
                push(1); check("full_ready_last", ld_ready);
            end
            tick();
        end
        push(13'h1000); check("full_count", load_count);
        push(0); check("full_ready_after", ld_ready);
        push(0); check("full_cpu_rst_entry", cpu_reset_n);
        ld_data = 8'hEE;
        tick();
        ld_valid = 1'b0;
        push(13'h1000); check("full_no_wrap", load_count);
        push(1); check("full_cpu_rst_run", cpu_reset_n);
        M_address = 12'h000; #1; push(pat(0)); check("full_ram000", M_data_in);
        M_address = 12'h800; #1; push(pat(12'h800)); check("full_ram800", M_data_in);
        M_address = 12'hFEF; #1; push(pat(12'hFEF)); check("full_ramFEF", M_data_in);

        // Write protect region behaviour
        M_address = 12'h050; M_data_out = 8'h77; write_read = 1'b1;
        tick();
        write_read = 1'b0;
`ifdef MEM_WRITE_PROTECT_EN
        push(pat(12'h050)); check("wp_ram050", M_data_in);
        push(1); check("wp_flag", wp_violation);
`else
        push(8'h77); check("wp_ram050", M_data_in);
        push(0); check("wp_flag", wp_violation);
`endif
        M_address = 12'h200; M_data_out = 8'h99; write_read = 1'b1;
        tick();
        write_read = 1'b0;
        push(8'h99); check("wp_ram200", M_data_in);
`ifdef MEM_WRITE_PROTECT_EN
        push(1); check("wp_sticky", wp_violation);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        push(0); check("wp_clear_on_load", wp_violation);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
